// File: rtl/mem_stall_responder_if.sv
// -----------------------------------------------------------------------------
// mem_stall_responder_if : requester <-> data-memory responder bus   | rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface mem_stall_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Stall;
  logic        Done;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, Stall, Done, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, Stall, Done, err
  );
endinterface

`default_nettype wire

// File: rtl/mem_stall_responder.sv
// -----------------------------------------------------------------------------
// mem_stall_responder : fixed-latency stalling word memory for the MEM stage | rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_stall_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stall_responder_if.slave  bus
);

  localparam int         c_depth      = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_last_count = 4'(LATENCY - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [3:0]            r_count;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [15:0]           r_data;
  logic                  r_is_wr;
  logic [15:0]           r_dout;
  logic [15:0]           r_mem [c_depth];

  logic                  w_legal;
  logic                  w_illegal;
  logic                  w_accept;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_rd_kind;
  logic                  w_unused_addr;

  assign w_legal       = (bus.Rd ^ bus.Wr) & ~bus.Addr[0];
  assign w_illegal     = (bus.Rd | bus.Wr) & ~w_legal;
  assign w_accept      = (r_state == c_idle) & w_legal;
  assign w_unused_addr = ^bus.Addr;

  // With LATENCY=1 the DONE cycle follows accept directly, so the read index
  // must come from the live bus rather than the not-yet-latched copy.
  assign w_rd_idx  = w_accept ? bus.Addr[DEPTH_LOG2:1] : r_idx;
  assign w_rd_kind = w_accept ? bus.Rd : ~r_is_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: if (w_legal) w_state_next = (LATENCY == 1) ? c_done : c_busy;
      c_busy: if (r_count == c_last_count) w_state_next = c_done;
      c_done: w_state_next = c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  always_comb begin
    bus.Stall   = w_accept | (r_state == c_busy);
    bus.Done    = (r_state == c_done);
    bus.err     = (r_state == c_idle) & w_illegal;
    bus.DataOut = r_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
      r_idx   <= '0;
      r_data  <= 16'h0000;
      r_is_wr <= 1'b0;
      r_dout  <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_count <= 4'd1;
        r_idx   <= bus.Addr[DEPTH_LOG2:1];
        r_data  <= bus.DataIn;
        r_is_wr <= bus.Wr;
      end else if (r_state == c_busy) begin
        r_count <= r_count + 4'd1;
      end
      if ((w_state_next == c_done) && w_rd_kind)
        r_dout <= r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_depth; i++) r_mem[i] <= 16'h0000;
    end else if ((r_state == c_done) && r_is_wr) begin
      r_mem[r_idx] <= r_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stall_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_stall_responder : directed self-checking bench, LATENCY 4 and 1 | rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_mem_stall_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass  = 0;
  int   ntotal = 0;

  mem_stall_responder_if ifa ();
  mem_stall_responder_if ifb ();

  mem_stall_responder #(.DEPTH_LOG2(8), .LATENCY(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  mem_stall_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Runs one LATENCY=4 access from cycle 0 through the DONE cycle, recording
  // Stall/Done per cycle and DataOut in cycle 4; returns in cycle 5.
  task automatic acc_a(input bit wr, input logic [15:0] addr, input logic [15:0] din,
                       output logic [4:0] sv, output logic [4:0] dv, output logic [15:0] dout);
    ifa.Addr = addr; ifa.DataIn = din; ifa.Rd = ~wr; ifa.Wr = wr;
    dout = 16'hxxxx;
    for (int c = 0; c <= 4; c++) begin
      #1;
      sv[c] = ifa.Stall;
      dv[c] = ifa.Done;
      if (c == 4) dout = ifa.DataOut;
      tick;
      if (c == 0) begin ifa.Rd = 1'b0; ifa.Wr = 1'b0; end
    end
  endtask

  task automatic test_reset;
    #1;
    ntotal++; if (ifa.Stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", ifa.Stall); else npass++;
    ntotal++; if (ifa.Done !== 1'b0) $display("FAIL reset_done: got %b want 0", ifa.Done); else npass++;
    ntotal++; if (ifa.err !== 1'b0) $display("FAIL reset_err: got %b want 0", ifa.err); else npass++;
    ntotal++; if (ifa.DataOut !== 16'h0000) $display("FAIL reset_dataout: got %h want 0000", ifa.DataOut); else npass++;
    tick;
    rst = 1'b0;
    tick;
    #1;
    ntotal++; if (ifa.Stall !== 1'b0) $display("FAIL idle_stall: got %b want 0", ifa.Stall); else npass++;
  endtask

  task automatic test_first_read;
    logic [4:0] sv, dv; logic [15:0] d;
    acc_a(1'b0, 16'h0010, 16'h0000, sv, dv, d);
    ntotal++; if (sv !== 5'b01111) $display("FAIL read_stall_pattern: got %b want 01111", sv); else npass++;
    ntotal++; if (dv !== 5'b10000) $display("FAIL read_done_pattern: got %b want 10000", dv); else npass++;
    ntotal++; if (d !== 16'h0000) $display("FAIL read_data_zero: got %h want 0000", d); else npass++;
  endtask

  task automatic test_back_to_back;
    logic [4:0] sv, dv; logic [15:0] d;
    acc_a(1'b1, 16'h0020, 16'hBEEF, sv, dv, d);
    ntotal++; if (dv !== 5'b10000) $display("FAIL write_done_pattern: got %b want 10000", dv); else npass++;
    acc_a(1'b0, 16'h0020, 16'h0000, sv, dv, d);
    ntotal++; if (sv !== 5'b01111) $display("FAIL b2b_stall_pattern: got %b want 01111", sv); else npass++;
    ntotal++; if (dv !== 5'b10000) $display("FAIL b2b_done_pattern: got %b want 10000", dv); else npass++;
    ntotal++; if (d !== 16'hBEEF) $display("FAIL raw_data: got %h want beef", d); else npass++;
  endtask

  task automatic test_alias;
    logic [4:0] sv, dv; logic [15:0] d;
    acc_a(1'b1, 16'h0002, 16'h1234, sv, dv, d);
    acc_a(1'b0, 16'h0202, 16'h0000, sv, dv, d);
    ntotal++; if (d !== 16'h1234) $display("FAIL alias_data: got %h want 1234", d); else npass++;
  endtask

  task automatic test_illegal;
    logic [4:0] sv, dv; logic [15:0] d;
    ifa.Addr = 16'h0004; ifa.Rd = 1'b1; ifa.Wr = 1'b1;
    #1;
    ntotal++; if (ifa.err !== 1'b1) $display("FAIL ill_both_err: got %b want 1", ifa.err); else npass++;
    ntotal++; if (ifa.Stall !== 1'b0) $display("FAIL ill_both_stall: got %b want 0", ifa.Stall); else npass++;
    tick;
    ifa.Rd = 1'b0; ifa.Wr = 1'b0;
    #1;
    ntotal++; if ({ifa.err, ifa.Stall, ifa.Done} !== 3'b000) $display("FAIL ill_both_after: got %b want 000", {ifa.err, ifa.Stall, ifa.Done}); else npass++;
    ifa.Addr = 16'h0005; ifa.Rd = 1'b1;
    #1;
    ntotal++; if (ifa.err !== 1'b1) $display("FAIL ill_odd_err: got %b want 1", ifa.err); else npass++;
    ntotal++; if (ifa.Stall !== 1'b0) $display("FAIL ill_odd_stall: got %b want 0", ifa.Stall); else npass++;
    tick;
    ifa.Rd = 1'b0;
    #1;
    ntotal++; if ({ifa.err, ifa.Stall, ifa.Done} !== 3'b000) $display("FAIL ill_odd_after: got %b want 000", {ifa.err, ifa.Stall, ifa.Done}); else npass++;
    ntotal++; if (ifa.DataOut !== 16'h1234) $display("FAIL dataout_hold: got %h want 1234", ifa.DataOut); else npass++;
    acc_a(1'b0, 16'h0004, 16'h0000, sv, dv, d);
    ntotal++; if (sv !== 5'b01111) $display("FAIL post_ill_stall: got %b want 01111", sv); else npass++;
    ntotal++; if (d !== 16'h0000) $display("FAIL post_ill_data: got %h want 0000", d); else npass++;
  endtask

  task automatic test_input_change;
    logic [4:0] sv, dv; logic [15:0] d;
    ifa.Addr = 16'h0008; ifa.DataIn = 16'hAAAA; ifa.Wr = 1'b1; ifa.Rd = 1'b0;
    tick;
    ifa.Addr = 16'h000A; ifa.DataIn = 16'h5555; ifa.Rd = 1'b1; ifa.Wr = 1'b1;
    #1;
    ntotal++; if ({ifa.err, ifa.Stall} !== 2'b01) $display("FAIL busy_err_stall: got %b want 01", {ifa.err, ifa.Stall}); else npass++;
    tick; tick; tick;
    ifa.Wr = 1'b0;
    #1;
    ntotal++; if ({ifa.Done, ifa.Stall} !== 2'b10) $display("FAIL done_rd_held: got %b want 10", {ifa.Done, ifa.Stall}); else npass++;
    tick;
    ifa.Rd = 1'b0; ifa.Addr = 16'h0000;
    #1;
    ntotal++; if ({ifa.Done, ifa.Stall} !== 2'b00) $display("FAIL no_reaccept: got %b want 00", {ifa.Done, ifa.Stall}); else npass++;
    acc_a(1'b0, 16'h0008, 16'h0000, sv, dv, d);
    ntotal++; if (d !== 16'hAAAA) $display("FAIL latched_data: got %h want aaaa", d); else npass++;
    acc_a(1'b0, 16'h000A, 16'h0000, sv, dv, d);
    ntotal++; if (d !== 16'h0000) $display("FAIL unwritten_word: got %h want 0000", d); else npass++;
  endtask

  task automatic test_reset_mid;
    logic [4:0] sv, dv; logic [15:0] d;
    ifa.Addr = 16'h0030; ifa.DataIn = 16'hCAFE; ifa.Wr = 1'b1;
    tick;
    ifa.Wr = 1'b0;
    tick;
    #1;
    ntotal++; if (ifa.Stall !== 1'b1) $display("FAIL busy2_stall: got %b want 1", ifa.Stall); else npass++;
    rst = 1'b1;
    #1;
    ntotal++; if ({ifa.Stall, ifa.Done, ifa.err} !== 3'b000) $display("FAIL async_reset: got %b want 000", {ifa.Stall, ifa.Done, ifa.err}); else npass++;
    tick;
    rst = 1'b0;
    tick;
    #1;
    ntotal++; if (ifa.DataOut !== 16'h0000) $display("FAIL reset_dataout_clr: got %h want 0000", ifa.DataOut); else npass++;
    acc_a(1'b0, 16'h0030, 16'h0000, sv, dv, d);
    ntotal++; if (d !== 16'h0000) $display("FAIL discarded_write: got %h want 0000", d); else npass++;
    acc_a(1'b0, 16'h0020, 16'h0000, sv, dv, d);
    ntotal++; if (d !== 16'h0000) $display("FAIL array_cleared: got %h want 0000", d); else npass++;
  endtask

  task automatic test_latency1;
    ifb.Addr = 16'h0030; ifb.DataIn = 16'hCAFE; ifb.Wr = 1'b1;
    #1;
    ntotal++; if ({ifb.Stall, ifb.Done} !== 2'b10) $display("FAIL l1_wr_c0: got %b want 10", {ifb.Stall, ifb.Done}); else npass++;
    tick;
    ifb.Wr = 1'b0;
    #1;
    ntotal++; if ({ifb.Stall, ifb.Done} !== 2'b01) $display("FAIL l1_wr_c1: got %b want 01", {ifb.Stall, ifb.Done}); else npass++;
    tick;
    ifb.Rd = 1'b1;
    #1;
    ntotal++; if (ifb.Stall !== 1'b1) $display("FAIL l1_rd_stall: got %b want 1", ifb.Stall); else npass++;
    tick;
    ifb.Rd = 1'b0;
    #1;
    ntotal++; if ({ifb.Done, ifb.DataOut} !== {1'b1, 16'hCAFE}) $display("FAIL l1_rd_done: got %b/%h want 1/cafe", ifb.Done, ifb.DataOut); else npass++;
    tick;
    #1;
    ntotal++; if (ifb.Done !== 1'b0) $display("FAIL l1_done_pulse: got %b want 0", ifb.Done); else npass++;
    ifb.DataIn = 16'h1111; ifb.Wr = 1'b1;
    tick;
    ifb.Wr = 1'b0;
    #1;
    ntotal++; if (ifb.Done !== 1'b1) $display("FAIL l1_wr2_done: got %b want 1", ifb.Done); else npass++;
    rst = 1'b1;
    #1;
    ntotal++; if (ifb.Done !== 1'b0) $display("FAIL l1_reset_in_done: got %b want 0", ifb.Done); else npass++;
    tick;
    rst = 1'b0;
    tick;
    ifb.Rd = 1'b1;
    tick;
    ifb.Rd = 1'b0;
    #1;
    ntotal++; if ({ifb.Done, ifb.DataOut} !== {1'b1, 16'h0000}) $display("FAIL l1_after_reset: got %b/%h want 1/0000", ifb.Done, ifb.DataOut); else npass++;
  endtask

  initial begin
    ifa.Addr = 16'h0000; ifa.DataIn = 16'h0000; ifa.Rd = 1'b0; ifa.Wr = 1'b0;
    ifb.Addr = 16'h0000; ifb.DataIn = 16'h0000; ifb.Rd = 1'b0; ifb.Wr = 1'b0;
    tick;
    test_reset;
    test_first_read;
    test_back_to_back;
    test_alias;
    test_illegal;
    test_input_change;
    test_reset_mid;
    test_latency1;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stall_responder.md
# mem_stall_responder

Multi-cycle data-memory responder for the pipelined processor's memory stage. It accepts one word read or write at a time from the processor and holds the pipeline with `Stall` for a fixed, programmable latency. It then completes the access with a one-cycle `Done` pulse. It replaces the single-cycle data memory so that the processor's stall path is exercised end to end.

## Interface
Parameters:
- `DEPTH_LOG2`, default 8: the backing array holds 2^DEPTH_LOG2 16-bit words.
- `LATENCY`, default 4: number of `Stall` cycles per access. Legal range is 1..15.

Ports:
- `clk`, input, 1: the only clock. Everything is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `Addr`, input, 16: byte address. Bit 0 must be 0.
- `DataIn`, input, 16: write data.
- `Rd`, input, 1: read request.
- `Wr`, input, 1: write request.
- `DataOut`, output, 16: read data. Valid while `Done` is high on a read.
- `Stall`, output, 1: the responder is busy and the requester must hold the pipeline.
- `Done`, output, 1: the access completes this cycle. One-cycle pulse.
- `err`, output, 1: an illegal request was presented this cycle.

## Operation
- States are IDLE, BUSY and DONE. Reset state is IDLE.
- Legal request in IDLE: exactly one of `Rd` and `Wr` is high, and `Addr[0]` is 0.
- On accepting a legal request, the block latches `Addr`, `DataIn` and the read/write kind. The count loads 1.
  - LATENCY = 1: go to DONE.
  - Otherwise: go to BUSY.
- BUSY: the count increments each cycle. When count = LATENCY-1, go to DONE on the next edge.
- DONE:
  - For a read, `DataOut` takes the array word.
  - For a write, the array word is updated at the end of the cycle.
  - Always go to IDLE.
- `Stall` is combinational. It is high in the accept cycle (IDLE with a legal request) and in every BUSY cycle. It is low in DONE and when IDLE has no legal request.
- `Done` is high only in DONE.
- Request inputs are ignored in BUSY and DONE. A request still asserted during DONE is not re-accepted.
- Illegal request in IDLE (`Rd` & `Wr` both high, or (`Rd` | `Wr`) with `Addr[0]` = 1):
  - `err` is high combinationally in that cycle.
  - The request is dropped: no `Stall`, no `Done`, no array change, and the state stays IDLE.
- `err` is 0 in every state other than IDLE.
- Word index is `Addr[DEPTH_LOG2:1]`. Upper address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
- `DataOut` holds its last read value across writes and idle cycles.

## Timing
- Reset values:
  - state IDLE, count 0.
  - `DataOut` = 0x0000, `Done` = 0, `err` = 0.
  - `Stall` = 0 when no legal request is presented.
  - Every array word = 0x0000.
- Legal request presented at cycle 0:
  - `Stall` is high in cycles 0..LATENCY-1.
  - In cycle LATENCY: `Done` = 1, `Stall` = 0, and read data is on `DataOut`.
- Throughput: the earliest next accept is cycle LATENCY+1, so one access per LATENCY+1 cycles.
- Read-after-write to the same word: a read accepted after the write's DONE returns the new data.
- `rst` asserted in any state, including mid-BUSY or DONE:
  - Immediate return to IDLE with `Stall`, `Done` and `err` low.
  - A pending write is discarded and the array is cleared.
- The block does not depend on the requester holding its inputs while `Stall` is high, because they are latched at accept.

## Test plan
- Reset, then read `Addr` = 0x0010 with LATENCY = 4 -> `Stall` high for cycles 0..3; cycle 4 has `Done` = 1, `Stall` = 0, `DataOut` = 0x0000.
- Write 0xBEEF to 0x0020, then read 0x0020 -> the write's `Done` comes at cycle 4, the read is accepted at cycle 5 and its `Done` comes at cycle 9 with `DataOut` = 0xBEEF.
- Aliasing with DEPTH_LOG2 = 8: write 0x1234 to 0x0002, then read 0x0202 -> `DataOut` = 0x1234.
- Illegal requests:
  - `Rd` and `Wr` both high at 0x0004 -> `err` = 1 for one cycle, no `Stall`, state stays IDLE.
  - `Rd` at 0x0005 -> same response.
  - A following legal read of 0x0004 is unaffected and returns 0x0000.
- Inputs changed mid-access: during BUSY of a write of 0xAAAA to 0x0008, change `Addr`/`DataIn` to 0x000A/0x5555 -> 0x0008 reads 0xAAAA and 0x000A reads 0x0000. `Rd` kept high through DONE causes no second accept.
- Reset mid-access: assert `rst` in the 2nd BUSY cycle of a write of 0xCAFE to 0x0030 -> `Stall` drops immediately and a later read of 0x0030 returns 0x0000. Repeat with LATENCY = 1 -> `Stall` for one cycle, `Done` in the next.
